rr_lock_arbiter: RTL
====================

Name: rr_lock_arbiter

Overview:
Synthesizable round-robin arbiter that shares one resource among N requesters. It pairs with the round-robin grant checker in the same codebase.
- Issues a one-hot registered grant to the first requester at or after a rotating priority pointer.
- Holds (locks) that grant until the owner releases, the resource signals done, or a hold-timeout expires.
- After every grant ends, the pointer advances past the last owner.

Parameters:
N, 8, number of requesters (2..16; non-power-of-two allowed)
MAX_HOLD, 16, maximum grant duration in cycles before forced release (>=2)
IDW, $clog2(N), width of gnt_id (derived, not overridden)

Ports:
clk  in  1  clock, all logic on posedge
reset_n  in  1  reset, synchronous, active-low
en  in  1  arbitration enable; low blocks new grants, does not end an active grant
req  in  N  request vector, bit i = requester i
res_done  in  1  single-cycle pulse from resource: current transaction complete
gnt  out  N  one-hot grant, registered
gnt_id  out  IDW  index of current/last owner
gnt_valid  out  1  high whenever gnt != 0
timeout  out  1  single-cycle pulse on forced release
ptr  out  IDW  current priority pointer (debug/checker visibility)

Behaviour:
- Reset (reset_n low at posedge):
  - state=IDLE; gnt=0, gnt_valid=0, gnt_id=0, ptr=0, timeout=0, hold_cnt=0.
  - Reset applied mid-grant clears gnt at that same edge.
- FSM states: IDLE, GRANT.
- IDLE:
  - If en && |req, pick winner w = first i in circular order ptr, ptr+1, ..., N-1, 0, ..., ptr-1 with req[i]=1.
  - Next edge: gnt=1<<w, gnt_id=w, gnt_valid=1, hold_cnt=0, state=GRANT.
  - Latency: req sampled at edge k produces gnt visible after edge k+1.
  - Otherwise stay in IDLE with gnt=0.
- GRANT:
  - hold_cnt increments every cycle.
  - End condition (evaluated each edge): !req[gnt_id] OR res_done OR hold_cnt==MAX_HOLD-1.
  - On end: gnt=0, gnt_valid=0, state=IDLE, ptr=(gnt_id==N-1)?0:gnt_id+1.
  - gnt_id keeps its value after release.
- Maximum grant length: exactly MAX_HOLD cycles.
- Dead cycle: a mandatory one-cycle gap with gnt=0 follows every grant. The minimum grant-to-grant spacing is therefore 1 idle cycle.
- timeout:
  - Pulses in the release cycle only when the hold limit caused the release.
  - If res_done or the req drop coincides with the limit, the release is normal and timeout=0.
- Simultaneous events: res_done and req drop in the same cycle count as one release with one pointer advance.
- en does not affect an active grant. en low in IDLE holds off arbitration; ptr is unchanged.
- Pointer wraps from N-1 to 0, with no gap values for non-power-of-two N.
- Invariants (for SVA): $onehot0(gnt); gnt_valid == |gnt; a new grant is never issued to a requester whose req is low; gnt never changes owner without a 0 cycle between owners.

Decomposition:
- Package rr_arb_pkg holds:
  - arb_state_e enum {IDLE, GRANT}
  - function next_ptr(id, n), the wrap-increment
  - localparam defaults for N/MAX_HOLD
- One sub-module, rr_pick: purely combinational circular priority encoder.
  - Inputs: req[N], ptr.
  - Outputs: any, win_id.
  - Implemented as a double-width request vector masked by ptr.
- Top module holds the FSM, hold counter, pointer and output registers.

Test Plan:
1. Reset, then req=8'h04, en=1 at edge k -> gnt=8'h04, gnt_id=2 after edge k+1; req dropped at k+4 -> gnt=0 after k+5, ptr=3.
2. Rotation: req=8'hFF constant, res_done pulsed 3 cycles into each grant -> gnt_id sequence 0,1,2,...,7,0, each grant 3 cycles long followed by exactly 1 gnt=0 cycle.
3. Wrap/skip: ptr=3 (after granting 2), req=8'b0000_0011 -> winner gnt_id=0, then ptr=1; next winner id 1.
4. Timeout: only req[5] held high, no res_done -> gnt=8'h20 for 16 cycles, timeout pulse in the release cycle, 1 idle cycle, re-grant to id 5. Repeat with res_done on the 16th cycle -> timeout stays 0.
5. Reset mid-grant: grant to id 6 active, reset_n low for 1 edge -> gnt=0, ptr=0 after that edge; req=8'h41 afterwards -> grant id 0.
6. en gating: en=0, req=8'h10 for 5 cycles -> gnt stays 0. en=1 at edge k -> gnt=8'h10 after k+1. en dropped during the grant -> grant continues until release.

Source files
------------

// File: rtl/rr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_pkg
// Description : Shared types, defaults and pointer helper for rr_lock_arbiter.
// Revision    : 1.0
// ============================================================================
package rr_arb_pkg;

    localparam int DEF_N        = 8;
    localparam int DEF_MAX_HOLD = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Advance past an owner, wrapping N-1 back to 0 with no unused codes.
    function automatic int next_ptr(input int id, input int n);
        return (id == n - 1) ? 0 : id + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational circular priority encoder starting at ptr.
// Revision    : 1.0
// ============================================================================
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] win_id
);

    localparam int DW = $clog2(2 * N);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] masked;
    logic [DW-1:0]  first;

    assign dbl = {req, req};
    assign any = |req;

    // Lower copy is masked below ptr, so the lowest set bit of the doubled
    // vector is the first requester in circular order from ptr.
    always_comb begin
        masked = '0;
        first  = '0;
        for (int i = 0; i < 2 * N; i++) begin
            masked[i] = dbl[i] & (i >= int'(ptr));
        end
        for (int i = 2 * N - 1; i >= 0; i--) begin
            if (masked[i]) begin
                first = DW'(i);
            end
        end
    end

    assign win_id = (first >= DW'(N)) ? IDW'(first - DW'(N)) : IDW'(first);

endmodule
`default_nettype wire

// File: rtl/rr_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_lock_arbiter
// Description : Round-robin arbiter with grant locking, done/drop release and
//               hold timeout; one dead cycle follows every grant.
// Revision    : 1.0
// ============================================================================
module rr_lock_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [N-1:0]         req,
    input  logic                 res_done,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 gnt_valid,
    output logic                 timeout,
    output logic [$clog2(N)-1:0] ptr
);

    localparam int IDW = $clog2(N);
    localparam int HW  = $clog2(MAX_HOLD);

    arb_state_e     state, state_nx;
    logic [N-1:0]   gnt_nx;
    logic [IDW-1:0] gnt_id_nx;
    logic [IDW-1:0] ptr_nx;
    logic           timeout_nx;
    logic [HW-1:0]  hold_cnt, hold_nx;

    logic           any;
    logic [IDW-1:0] win_id;
    logic           owner_req;
    logic           at_limit;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .any    (any),
        .win_id (win_id)
    );

    assign owner_req = req[gnt_id];
    assign at_limit  = (hold_cnt == HW'(MAX_HOLD - 1));

    always_comb begin
        state_nx   = state;
        gnt_nx     = gnt;
        gnt_id_nx  = gnt_id;
        ptr_nx     = ptr;
        timeout_nx = 1'b0;
        hold_nx    = hold_cnt;
        unique case (state)
            IDLE: begin
                gnt_nx  = '0;
                hold_nx = '0;
                if (en && any) begin
                    gnt_nx    = N'(1) << win_id;
                    gnt_id_nx = win_id;
                    state_nx  = GRANT;
                end
            end
            GRANT: begin
                if (!owner_req || res_done || at_limit) begin
                    gnt_nx     = '0;
                    state_nx   = IDLE;
                    hold_nx    = '0;
                    ptr_nx     = IDW'(next_ptr(int'(gnt_id), N));
                    // Only a pure hold-limit release counts as a timeout.
                    timeout_nx = owner_req && !res_done;
                end else begin
                    hold_nx = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            ptr      <= '0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            gnt      <= gnt_nx;
            gnt_id   <= gnt_id_nx;
            ptr      <= ptr_nx;
            timeout  <= timeout_nx;
            hold_cnt <= hold_nx;
        end
    end

    assign gnt_valid = |gnt;

endmodule
`default_nettype wire
